id_mex_pipe: RTL and testbench

//  Decode-to-MEX pipeline register with load-use hazard detection. Captures decoded operand
//  and write-register fields from ID and presents them to the MEX stage and forwarding unit
//  (id_mex_reg1/reg2/alu_src). Inserts a one-cycle bubble and stalls IF/ID on a load-use

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/id_mex_pipe_hazard_detect.sv | 28 ++
 rtl/id_mex_pipe.sv | 103 ++++++++++
 tb/tb_id_mex_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared widths, FSM state and the ID->MEX pipeline-slot record for the
// decode-to-MEX register and its hazard logic.
package pipe_pkg;

  localparam int REG_W  = 3;
  localparam int DATA_W = 8;
  localparam int OP_W   = 4;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  reg1;
    logic [REG_W-1:0]  reg2;
    logic [REG_W-1:0]  wrt_reg;
    logic              reg_write;
    logic              mem_read;
    logic              alu_src;
    logic [DATA_W-1:0] imm;
    logic [OP_W-1:0]   alu_op;
  } id_mex_t;

endpackage

// File: rtl/id_mex_pipe_hazard_detect.sv
// Load-use hazard compare: the instruction in ID reads the destination of a
// valid load currently sitting in the MEX slot.
module hazard_detect #(
  parameter int REG_W = pipe_pkg::REG_W
) (
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_reg1,
  input  logic [REG_W-1:0] id_reg2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             mex_valid,
  input  logic             mex_mem_read,
  input  logic             mex_reg_write,
  input  logic [REG_W-1:0] mex_wrt_reg,
  output logic             hazard
);

  logic match1;
  logic match2;

  always_comb begin
    match1 = id_use1 && (id_reg1 == mex_wrt_reg);
    match2 = id_use2 && (id_reg2 == mex_wrt_reg);
    hazard = id_valid && mex_valid && mex_mem_read && mex_reg_write
             && (match1 || match2);
  end

endmodule

// File: rtl/id_mex_pipe.sv
// ID->MEX pipeline register: captures decoded fields, inserts a one-cycle
// bubble on load-use hazards, holds while MEX is busy and squashes on flush.
module id_mex_pipe #(
  parameter int REG_W  = pipe_pkg::REG_W,
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int OP_W   = pipe_pkg::OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_reg1,
  input  logic [REG_W-1:0]  id_reg2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic [REG_W-1:0]  id_wrt_reg,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_alu_src,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [OP_W-1:0]   id_alu_op,
  input  logic              flush,
  input  logic              mex_busy,
  output logic              stall,
  output logic              id_mex_valid,
  output logic [REG_W-1:0]  id_mex_reg1,
  output logic [REG_W-1:0]  id_mex_reg2,
  output logic [REG_W-1:0]  id_mex_wrt_reg,
  output logic              id_mex_reg_write,
  output logic              id_mex_mem_read,
  output logic              id_mex_alu_src,
  output logic [DATA_W-1:0] id_mex_imm,
  output logic [OP_W-1:0]   id_mex_alu_op
);

  import pipe_pkg::*;

  id_mex_t slot_q;
  state_e  state_q;
  logic    hazard;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .id_valid      (id_valid),
    .id_reg1       (id_reg1),
    .id_reg2       (id_reg2),
    .id_use1       (id_use1),
    .id_use2       (id_use2),
    .mex_valid     (slot_q.valid),
    .mex_mem_read  (slot_q.mem_read),
    .mex_reg_write (slot_q.reg_write),
    .mex_wrt_reg   (slot_q.wrt_reg),
    .hazard        (hazard)
  );

  always_comb begin
    stall = !flush && (mex_busy || (hazard && state_q == RUN));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q  <= '0;
      state_q <= RUN;
    end else if (flush) begin
      slot_q.valid     <= 1'b0;
      slot_q.reg_write <= 1'b0;
      slot_q.mem_read  <= 1'b0;
      state_q          <= RUN;
    end else if (mex_busy) begin
      slot_q  <= slot_q;
      state_q <= state_q;
    end else if (hazard && state_q == RUN) begin
      slot_q  <= '0;
      state_q <= BUBBLE;
    end else if (id_valid) begin
      slot_q.valid     <= 1'b1;
      slot_q.reg1      <= id_reg1;
      slot_q.reg2      <= id_reg2;
      slot_q.wrt_reg   <= id_wrt_reg;
      slot_q.reg_write <= id_reg_write;
      slot_q.mem_read  <= id_mem_read;
      slot_q.alu_src   <= id_alu_src;
      slot_q.imm       <= id_imm;
      slot_q.alu_op    <= id_alu_op;
      state_q          <= RUN;
    end else begin
      // An empty ID slot enters MEX as a fully zeroed bubble.
      slot_q  <= '0;
      state_q <= RUN;
    end
  end

  always_comb begin
    id_mex_valid     = slot_q.valid;
    id_mex_reg1      = slot_q.reg1;
    id_mex_reg2      = slot_q.reg2;
    id_mex_wrt_reg   = slot_q.wrt_reg;
    id_mex_reg_write = slot_q.reg_write;
    id_mex_mem_read  = slot_q.mem_read;
    id_mex_alu_src   = slot_q.alu_src;
    id_mex_imm       = slot_q.imm;
    id_mex_alu_op    = slot_q.alu_op;
  end

endmodule

// File: tb/tb_id_mex_pipe.sv
// Self-checking bench for id_mex_pipe: directed scenarios plus a randomized run
// compared against a behavioural model of the MEX slot.
module tb_id_mex_pipe;

  localparam int REG_W  = 3;
  localparam int DATA_W = 8;
  localparam int OP_W   = 4;
  localparam int VEC_W  = 1 + 3*REG_W + 3 + DATA_W + OP_W;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_use1, id_use2, id_reg_write, id_mem_read, id_alu_src;
  logic [REG_W-1:0] id_reg1, id_reg2, id_wrt_reg;
  logic [DATA_W-1:0] id_imm;
  logic [OP_W-1:0] id_alu_op;
  logic flush, mex_busy;
  logic stall, id_mex_valid, id_mex_reg_write, id_mex_mem_read, id_mex_alu_src;
  logic [REG_W-1:0] id_mex_reg1, id_mex_reg2, id_mex_wrt_reg;
  logic [DATA_W-1:0] id_mex_imm;
  logic [OP_W-1:0] id_mex_alu_op;

  int passed = 0;
  int total  = 0;

  // Model of what MEX should hold.
  logic m_valid, m_rw, m_mr, m_as;
  logic [REG_W-1:0] m_reg1, m_reg2, m_wrt;
  logic [DATA_W-1:0] m_imm;
  logic [OP_W-1:0] m_op;

  logic [VEC_W-1:0] obs, exp_vec;

  always #5 clk = ~clk;

  id_mex_pipe #(.REG_W(REG_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_reg1(id_reg1), .id_reg2(id_reg2),
    .id_use1(id_use1), .id_use2(id_use2), .id_wrt_reg(id_wrt_reg),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_alu_src(id_alu_src),
    .id_imm(id_imm), .id_alu_op(id_alu_op), .flush(flush), .mex_busy(mex_busy),
    .stall(stall), .id_mex_valid(id_mex_valid), .id_mex_reg1(id_mex_reg1),
    .id_mex_reg2(id_mex_reg2), .id_mex_wrt_reg(id_mex_wrt_reg),
    .id_mex_reg_write(id_mex_reg_write), .id_mex_mem_read(id_mex_mem_read),
    .id_mex_alu_src(id_mex_alu_src), .id_mex_imm(id_mex_imm), .id_mex_alu_op(id_mex_alu_op)
  );

  assign obs = {id_mex_valid, id_mex_reg1, id_mex_reg2, id_mex_wrt_reg, id_mex_reg_write,
                id_mex_mem_read, id_mex_alu_src, id_mex_imm, id_mex_alu_op};
  assign exp_vec = {m_valid, m_reg1, m_reg2, m_wrt, m_rw, m_mr, m_as, m_imm, m_op};

  // A bubble can never be the load being waited on, so the stall rule needs
  // no separate memory of "already stalled once".
  function automatic logic model_hazard();
    return id_valid && m_valid && m_mr && m_rw &&
           ((id_use1 && id_reg1 == m_wrt) || (id_use2 && id_reg2 == m_wrt));
  endfunction

  function automatic logic model_stall();
    if (flush) return 1'b0;
    return mex_busy || model_hazard();
  endfunction

  task automatic model_clear();
    {m_valid, m_reg1, m_reg2, m_wrt, m_rw, m_mr, m_as, m_imm, m_op} = '0;
  endtask

  // Advance one clock; model follows the same edge using the inputs held across it.
  task automatic tick();
    logic hz;
    hz = model_hazard();
    @(posedge clk);
    if (!rst_n) model_clear();
    else if (flush) begin
      m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0;
    end else if (mex_busy) begin
    end else if (hz || !id_valid) model_clear();
    else begin
      m_valid = 1'b1; m_reg1 = id_reg1; m_reg2 = id_reg2; m_wrt = id_wrt_reg;
      m_rw = id_reg_write; m_mr = id_mem_read; m_as = id_alu_src;
      m_imm = id_imm; m_op = id_alu_op;
    end
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [REG_W-1:0] r1, input logic [REG_W-1:0] r2,
                          input logic u1, input logic u2, input logic [REG_W-1:0] w,
                          input logic rw, input logic mr, input logic as,
                          input logic [DATA_W-1:0] imm, input logic [OP_W-1:0] op);
    id_valid = v; id_reg1 = r1; id_reg2 = r2; id_use1 = u1; id_use2 = u2;
    id_wrt_reg = w; id_reg_write = rw; id_mem_read = mr; id_alu_src = as;
    id_imm = imm; id_alu_op = op;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; mex_busy = 1'b0;
    drive_id(1'b1, 3'd2, 3'd4, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b1, 8'hA5, 4'h7);
    model_clear();
    tick(); tick();
    total++;
    if (obs !== '0) $display("FAIL reset_outputs: got %h expected 0", obs);
    else passed++;
    #1;
    total++;
    if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall);
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_pass_through();
    drive_id(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1, 8'h05, 4'h2);
    #1;
    total++;
    if (stall !== 1'b0) $display("FAIL pass_stall: got %b expected 0", stall);
    else passed++;
    tick();
    total++;
    if (obs !== exp_vec || id_mex_wrt_reg !== 3'd1 || id_mex_imm !== 8'h05 ||
        id_mex_alu_src !== 1'b1 || id_mex_valid !== 1'b1)
      $display("FAIL pass_fields: got %h expected %h", obs, exp_vec);
    else passed++;
  endtask

  task automatic test_load_use();
    drive_id(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 8'h00, 4'h1);
    tick();
    drive_id(1'b1, 3'd3, 3'd2, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 8'h00, 4'h3);
    #1;
    total++;
    if (stall !== 1'b1) $display("FAIL loaduse_stall: got %b expected 1", stall);
    else passed++;
    tick();
    total++;
    if (id_mex_valid !== 1'b0 || obs !== '0)
      $display("FAIL loaduse_bubble: got %h expected 0", obs);
    else passed++;
    #1;
    total++;
    if (stall !== 1'b0) $display("FAIL loaduse_release: got %b expected 0", stall);
    else passed++;
    tick();
    total++;
    if (obs !== exp_vec || id_mex_reg1 !== 3'd3 || id_mex_valid !== 1'b1)
      $display("FAIL loaduse_add: got %h expected %h", obs, exp_vec);
    else passed++;
  endtask

  task automatic test_no_false_hazard();
    drive_id(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 8'h00, 4'h1);
    tick();
    drive_id(1'b1, 3'd3, 3'd3, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b1, 8'h11, 4'h5);
    #1;
    total++;
    if (stall !== 1'b0) $display("FAIL nofalse_stall: got %b expected 0", stall);
    else passed++;
    id_valid = 1'b0; id_use1 = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0) $display("FAIL invalid_id_stall: got %b expected 0", stall);
    else passed++;
    tick();
    total++;
    if (obs !== '0) $display("FAIL invalid_id_bubble: got %h expected 0", obs);
    else passed++;
  endtask

  task automatic test_busy_hold();
    logic [VEC_W-1:0] held;
    drive_id(1'b1, 3'd5, 3'd6, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 8'h3C, 4'h9);
    tick();
    held = exp_vec;
    drive_id(1'b1, 3'd1, 3'd2, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1, 8'hC3, 4'h6);
    mex_busy = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      total++;
      if (stall !== 1'b1) $display("FAIL busy_stall[%0d]: got %b expected 1", i, stall);
      else passed++;
      tick();
      total++;
      if (obs !== held) $display("FAIL busy_hold[%0d]: got %h expected %h", i, obs, held);
      else passed++;
    end
    mex_busy = 1'b0;
    tick();
    total++;
    if (obs !== exp_vec || id_mex_imm !== 8'hC3)
      $display("FAIL busy_release: got %h expected %h", obs, exp_vec);
    else passed++;
  endtask

  task automatic test_flush();
    drive_id(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 8'h00, 4'h1);
    tick();
    drive_id(1'b1, 3'd0, 3'd2, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 8'h00, 4'h3);
    tick();
    mex_busy = 1'b1; flush = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0) $display("FAIL flush_stall: got %b expected 0", stall);
    else passed++;
    tick();
    mex_busy = 1'b0; flush = 1'b0;
    total++;
    if (id_mex_valid !== 1'b0 || id_mex_reg_write !== 1'b0 || id_mex_mem_read !== 1'b0)
      $display("FAIL flush_valid: got %b%b%b expected 000", id_mex_valid, id_mex_reg_write, id_mex_mem_read);
    else passed++;
    tick();
    total++;
    if (obs !== exp_vec || id_mex_valid !== 1'b1)
      $display("FAIL flush_resume: got %h expected %h", obs, exp_vec);
    else passed++;
    drive_id(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 8'h00, 4'h1);
    tick();
    drive_id(1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1, 8'h77, 4'h4);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if (obs !== '0) $display("FAIL reset_in_bubble: got %h expected 0", obs);
    else passed++;
    tick();
    total++;
    if (obs !== exp_vec || id_mex_reg1 !== 3'd4)
      $display("FAIL reset_resume: got %h expected %h", obs, exp_vec);
    else passed++;
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 400; i++) begin
      drive_id($urandom_range(9, 0) != 0, 3'($urandom_range(3, 0)), 3'($urandom_range(3, 0)),
               1'($urandom), 1'($urandom), 3'($urandom_range(3, 0)),
               1'($urandom), $urandom_range(1, 0) == 0, 1'($urandom),
               8'($urandom), 4'($urandom));
      mex_busy = $urandom_range(4, 0) == 0;
      flush    = $urandom_range(9, 0) == 0;
      rst_n    = $urandom_range(49, 0) != 0;
      #1;
      total++;
      if (stall !== model_stall())
        $display("FAIL rand_stall[%0d]: got %b expected %b", i, stall, model_stall());
      else passed++;
      tick();
      total++;
      if (obs !== exp_vec) $display("FAIL rand_slot[%0d]: got %h expected %h", i, obs, exp_vec);
      else passed++;
    end
    rst_n = 1'b1; flush = 1'b0; mex_busy = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_pass_through();
    test_load_use();
    test_no_false_hazard();
    test_busy_hold();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
